// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants: address width, reset vector and
// direction-counter encodings used by the fetch predictor.
package rv32i_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;

    // Encodings for the default 2-bit direction counter.
    localparam int          CTR_BITS_DEF = 2;
    localparam logic [1:0]  CTR_WEAK_NT  = 2'b01;
    localparam logic [1:0]  CTR_WEAK_T   = 2'b10;

    // Width-generic forms of the same encodings.
    function automatic int unsigned ctr_weak_t(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

    function automatic int unsigned ctr_weak_nt(input int bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: asynchronous lookup port plus a
// clocked resolution port that allocates entries and trains the counters.
module btb_table #(
    parameter int XLEN     = rv32i_pkg::XLEN,
    parameter int DEPTH    = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-3:0] rd_word,
    output logic            rd_hit,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-3:0] wr_word,
    input  logic            wr_taken,
    input  logic            wr_is_jump,
    input  logic [XLEN-1:0] wr_target
);
    import rv32i_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = XLEN - 2 - IDX_W;
    localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [DEPTH-1:0]                valid;
    logic [DEPTH-1:0]                jmp;
    logic [DEPTH-1:0][TAG_W-1:0]     tag;
    logic [DEPTH-1:0][XLEN-1:0]      target;
    logic [DEPTH-1:0][CTR_BITS-1:0]  ctr;

    logic [IDX_W-1:0] ridx, widx;
    logic [TAG_W-1:0] rtag, wtag;
    logic             whit;
    logic [CTR_BITS-1:0] wctr;

    assign ridx = rd_word[IDX_W-1:0];
    assign rtag = rd_word[XLEN-3 -: TAG_W];
    assign widx = wr_word[IDX_W-1:0];
    assign wtag = wr_word[XLEN-3 -: TAG_W];

    assign rd_hit    = valid[ridx] && (tag[ridx] == rtag);
    assign rd_taken  = rd_hit && (jmp[ridx] || ctr[ridx][CTR_BITS-1]);
    assign rd_target = target[ridx];

    assign whit = valid[widx] && (tag[widx] == wtag);
    assign wctr = ctr[widx];

    // Control state: reset clears valids and parks counters weakly not-taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) ctr[i] <= WEAK_NT;
        end else if (wr_en) begin
            if (wr_taken && !whit) begin
                valid[widx] <= 1'b1;
                ctr[widx]   <= wr_is_jump ? CTR_MAX : WEAK_T;
            end else if (wr_taken) begin
                ctr[widx] <= (wr_is_jump || wctr == CTR_MAX) ? CTR_MAX : wctr + 1'b1;
            end else if (whit) begin
                ctr[widx] <= wr_is_jump ? CTR_MAX : (wctr == '0) ? wctr : wctr - 1'b1;
            end
        end
    end

    // Payload needs no reset; it is ignored until the entry's valid bit is set.
    always_ff @(posedge clk) begin
        if (rst && wr_en && wr_taken) begin
            target[widx] <= wr_target;
            if (!whit) begin
                tag[widx] <= wtag;
                jmp[widx] <= wr_is_jump;
            end
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// IF-stage fetch address generator: BTB-driven prediction, mispredict
// detection against EX resolution, and a running mispredict counter.
module pc_predict_unit #(
    parameter int                  XLEN      = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0]     RESET_PC  = rv32i_pkg::RESET_PC,
    parameter int                  BTB_DEPTH = 16,
    parameter int                  CTR_BITS  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_is_jump,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic            flush,
    output logic [31:0]     mispredict_cnt
);
    import rv32i_pkg::*;

    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic            mispredict;
    logic [XLEN-1:0] next_pc;

    btb_table #(
        .XLEN     (XLEN),
        .DEPTH    (BTB_DEPTH),
        .CTR_BITS (CTR_BITS)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_word    (fetch_pc[XLEN-1:2]),
        .rd_hit     (btb_hit),
        .rd_taken   (pred_taken),
        .rd_target  (btb_target),
        .wr_en      (res_valid),
        .wr_word    (res_pc[XLEN-1:2]),
        .wr_taken   (res_taken),
        .wr_is_jump (res_is_jump),
        .wr_target  (res_target)
    );

    assign pred_target = btb_hit ? btb_target : fetch_pc + STEP;

    // Target only matters when the branch was actually taken.
    assign mispredict = res_valid &&
                        ((res_taken != res_pred_taken) ||
                         (res_taken && (res_target != res_pred_target)));
    assign flush = rst && mispredict;

    always_comb begin
        next_pc = fetch_pc + STEP;
        if (mispredict)      next_pc = res_taken ? res_target : res_pc + STEP;
        else if (stall)      next_pc = fetch_pc;
        else if (pred_taken) next_pc = pred_target;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc       <= RESET_PC;
            mispredict_cnt <= '0;
        end else begin
            fetch_pc <= next_pc;
            if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: stimulus queues hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_pc_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_is_jump;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        flush;
    logic [31:0] mispredict_cnt;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] cnt;
        int          step;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    pc_predict_unit #(
        .XLEN(32), .RESET_PC(32'h0), .BTB_DEPTH(16), .CTR_BITS(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_is_jump     (res_is_jump),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .flush           (flush),
        .mispredict_cnt  (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int stp, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", stp, name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("fetch_pc",       e.step, fetch_pc,            e.pc);
            chk("pred_taken",     e.step, {31'd0, pred_taken}, {31'd0, e.pt});
            chk("pred_target",    e.step, pred_target,         e.tgt);
            chk("flush",          e.step, {31'd0, flush},      {31'd0, e.fl});
            chk("mispredict_cnt", e.step, mispredict_cnt,      e.cnt);
        end
    end

    // Drive one cycle of inputs, queue the outputs expected in that cycle.
    task automatic step(input logic r, input logic st,
                        input logic rv, input logic [31:0] rpc, input logic jmp,
                        input logic tk, input logic [31:0] rt,
                        input logic rpt, input logic [31:0] rptgt,
                        input logic [31:0] epc, input logic ept, input logic [31:0] etgt,
                        input logic efl, input logic [31:0] ecnt);
        exp_t e;
        rst = r; stall = st;
        res_valid = rv; res_pc = rpc; res_is_jump = jmp; res_taken = tk;
        res_target = rt; res_pred_taken = rpt; res_pred_target = rptgt;
        e.pc = epc; e.pt = ept; e.tgt = etgt; e.fl = efl; e.cnt = ecnt; e.step = step_no;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] epc, input logic ept, input logic [31:0] etgt,
                        input logic [31:0] ecnt);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, epc, ept, etgt, 0, ecnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 0; stall = 0; res_valid = 0; res_pc = 0; res_is_jump = 0;
        res_taken = 0; res_target = 0; res_pred_taken = 0; res_pred_target = 0;
        @(posedge clk);
        #1;
        // reset with a would-be mispredict on the inputs: no flush, no update
        step(0, 0, 1, 32'h10, 0, 1, 32'h40, 0, 0,   32'h0, 0, 32'h4, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0,             32'h0, 0, 32'h4, 0, 0);
        // sequential fetch
        idle(32'h0, 0, 32'h4, 0);
        idle(32'h4, 0, 32'h8, 0);
        idle(32'h8, 0, 32'hC, 0);
        idle(32'hC, 0, 32'h10, 0);
        // cold taken branch at 0x10 -> 0x40
        step(1, 0, 1, 32'h10, 0, 1, 32'h40, 0, 0,   32'h10, 0, 32'h14, 1, 0);
        step(1, 0, 1, 32'hC, 0, 0, 0, 1, 32'h40,    32'h40, 0, 32'h44, 1, 1);
        // hysteresis: weakly taken, first not-taken flushes
        step(1, 0, 1, 32'h10, 0, 0, 0, 1, 32'h40,   32'h10, 1, 32'h40, 1, 2);
        step(1, 0, 1, 32'hC, 0, 0, 0, 1, 0,         32'h14, 0, 32'h18, 1, 3);
        step(1, 0, 1, 32'h10, 0, 0, 32'h40, 0, 0,   32'h10, 0, 32'h40, 0, 4);
        step(1, 0, 1, 32'h10, 0, 0, 0, 0, 0,        32'h14, 0, 32'h18, 0, 4);
        step(1, 0, 1, 32'hC, 0, 0, 0, 1, 0,         32'h18, 0, 32'h1C, 1, 4);
        idle(32'h10, 0, 32'h40, 5);
        // stall holds, mispredict overrides stall
        step(1, 1, 0, 0, 0, 0, 0, 0, 0,             32'h14, 0, 32'h18, 0, 5);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0,             32'h14, 0, 32'h18, 0, 5);
        step(1, 1, 1, 32'h7C, 0, 1, 32'h80, 0, 0,   32'h14, 0, 32'h18, 1, 5);
        // jalr at 0x20 allocated to 0x100, then resolves to 0x200
        step(1, 0, 1, 32'h20, 1, 1, 32'h100, 1, 32'h100, 32'h80, 0, 32'h84, 0, 6);
        step(1, 0, 1, 32'h1C, 0, 0, 0, 1, 0,        32'h84, 0, 32'h88, 1, 6);
        step(1, 0, 1, 32'h20, 1, 1, 32'h200, 1, 32'h100, 32'h20, 1, 32'h100, 1, 7);
        step(1, 0, 1, 32'h1C, 0, 0, 0, 1, 0,        32'h200, 0, 32'h204, 1, 8);
        idle(32'h20, 1, 32'h200, 9);
        // aliasing: 0x50 evicts 0x10 (same index)
        step(1, 0, 1, 32'h50, 0, 1, 32'h90, 0, 0,   32'h200, 0, 32'h204, 1, 9);
        step(1, 0, 1, 32'h4C, 0, 0, 0, 1, 0,        32'h90, 0, 32'h94, 1, 10);
        idle(32'h50, 1, 32'h90, 11);
        step(1, 0, 1, 32'hC, 0, 0, 0, 1, 0,         32'h90, 0, 32'h94, 1, 11);
        idle(32'h10, 0, 32'h14, 12);
        // mid-run reset discards the redirect and clears the counter
        step(0, 0, 1, 32'h30, 0, 1, 32'h300, 0, 0,  32'h14, 0, 32'h18, 0, 12);
        idle(32'h0, 0, 32'h4, 0);
        idle(32'h4, 0, 32'h8, 0);

        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
